// File: rtl/hash_engine_pkg.sv
// Shared types and default widths for the hash engine post-processing blocks.
//   gather_state_e : window gatherer FSM state
//   pe_decision_e  : per-PE decision taken by the slot decoder in a cycle
package hash_engine_pkg;

  localparam int unsigned DefNumHashPe    = 4;
  localparam int unsigned DefIssueWidth   = 8;
  localparam int unsigned DefAddrWidth    = 32;
  localparam int unsigned DefResWidth     = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StEmit    = 2'd2
  } gather_state_e;

  typedef enum logic [1:0] {
    PeIdle  = 2'd0,  // not matching the current window (stalled)
    PeStore = 2'd1,  // accepted and written into its slot
    PeDrop  = 2'd2   // accepted but discarded as unexpected
  } pe_decision_e;

endpackage

// File: rtl/pe_result_slot_decoder.sv
// Combinational per-PE decode for the window gatherer.
//   collect_i    : gatherer is in the collect state
//   pe_valid_i   : per-PE result valid
//   pe_addr_i    : per-PE request address, packed NumHashPe x AddrWidth
//   head_addr_i  : current window base
//   mask_i       : slots expecting a result
//   collected_i  : slots already filled
//   match_o      : PE targets the current window (becomes pe_ready)
//   store_o      : PE result must be written to its slot
//   drop_o       : PE result accepted but unexpected
//   slot_oh_o    : per-PE slot one-hot, packed NumHashPe x IssueWidth
//   accepted_o   : union of slots stored this cycle
module pe_result_slot_decoder
  import hash_engine_pkg::*;
#(
  parameter int unsigned NumHashPe  = DefNumHashPe,
  parameter int unsigned IssueWidth = DefIssueWidth,
  parameter int unsigned AddrWidth  = DefAddrWidth
) (
  input  logic                          collect_i,
  input  logic [NumHashPe-1:0]          pe_valid_i,
  input  logic [NumHashPe*AddrWidth-1:0] pe_addr_i,
  input  logic [AddrWidth-1:0]          head_addr_i,
  input  logic [IssueWidth-1:0]         mask_i,
  input  logic [IssueWidth-1:0]         collected_i,
  output logic [NumHashPe-1:0]          match_o,
  output logic [NumHashPe-1:0]          store_o,
  output logic [NumHashPe-1:0]          drop_o,
  output logic [NumHashPe*IssueWidth-1:0] slot_oh_o,
  output logic [IssueWidth-1:0]         accepted_o
);

  localparam int unsigned IssueLog2 = $clog2(IssueWidth);

  logic [AddrWidth-1:0]  addr;
  logic [IssueWidth-1:0] oh;
  logic [IssueWidth-1:0] claimed;
  pe_decision_e          decision;

  // Lower-index PEs win slot conflicts because claimed accumulates in index order.
  always_comb begin
    match_o   = '0;
    store_o   = '0;
    drop_o    = '0;
    slot_oh_o = '0;
    claimed   = '0;
    addr      = '0;
    oh        = '0;
    decision  = PeIdle;
    for (int i = 0; i < int'(NumHashPe); i++) begin
      addr     = pe_addr_i[i*AddrWidth +: AddrWidth];
      oh       = '0;
      oh[addr[IssueLog2-1:0]] = 1'b1;
      decision = PeIdle;
      if (collect_i && pe_valid_i[i] &&
          (addr[AddrWidth-1:IssueLog2] == head_addr_i[AddrWidth-1:IssueLog2])) begin
        if (((oh & mask_i) != '0) && ((oh & (collected_i | claimed)) == '0)) begin
          decision = PeStore;
          claimed  = claimed | oh;
        end else begin
          decision = PeDrop;
        end
      end
      slot_oh_o[i*IssueWidth +: IssueWidth] = oh;
      match_o[i] = (decision != PeIdle);
      store_o[i] = (decision == PeStore);
      drop_o[i]  = (decision == PeDrop);
    end
    accepted_o = claimed;
  end

endmodule

// File: rtl/post_hash_pe_gatherer.sv
// Gathers per-request results from the hash PEs into issue windows.
// A descriptor opens a window (base address, expected-slot mask, delimiter);
// PE results addressed into that window are stored by slot, and once every
// expected slot is filled the window is presented on the output handshake.
//   clk, rst                      : clock, asynchronous active-high reset
//   desc_valid/ready, desc_*      : window descriptor input
//   pe_valid/ready, pe_addr/result: per-PE result inputs (packed)
//   output_valid/ready, output_*  : gathered window output (registered)
//   err_unexpected                : sticky flag for dropped/unexpected results
module post_hash_pe_gatherer
  import hash_engine_pkg::*;
#(
  parameter int unsigned NUM_HASH_PE      = DefNumHashPe,
  parameter int unsigned HASH_ISSUE_WIDTH = DefIssueWidth,
  parameter int unsigned ADDR_WIDTH       = DefAddrWidth,
  parameter int unsigned RES_WIDTH        = DefResWidth
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                desc_valid,
  output logic                                desc_ready,
  input  logic [ADDR_WIDTH-1:0]               desc_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]         desc_mask,
  input  logic                                desc_delim,
  input  logic [NUM_HASH_PE-1:0]              pe_valid,
  output logic [NUM_HASH_PE-1:0]              pe_ready,
  input  logic [NUM_HASH_PE*ADDR_WIDTH-1:0]   pe_addr,
  input  logic [NUM_HASH_PE*RES_WIDTH-1:0]    pe_result,
  output logic                                output_valid,
  input  logic                                output_ready,
  output logic [ADDR_WIDTH-1:0]               output_head_addr,
  output logic [HASH_ISSUE_WIDTH-1:0]         output_mask,
  output logic [HASH_ISSUE_WIDTH*RES_WIDTH-1:0] output_result_vec,
  output logic                                output_delim,
  output logic                                err_unexpected
);

  localparam int unsigned W = HASH_ISSUE_WIDTH;

  gather_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [W-1:0]          mask_q, mask_d;
  logic                  delim_q, delim_d;
  logic [W-1:0]          collected_q, collected_d;
  logic [W*RES_WIDTH-1:0] results_q, results_d;
  logic                  err_q, err_d;

  logic [NUM_HASH_PE-1:0]   match, store, drop;
  logic [NUM_HASH_PE*W-1:0] slot_oh;
  logic [W-1:0]             accepted;
  logic                     load;

  pe_result_slot_decoder #(
    .NumHashPe  (NUM_HASH_PE),
    .IssueWidth (W),
    .AddrWidth  (ADDR_WIDTH)
  ) u_decoder (
    .collect_i   (state_q == StCollect),
    .pe_valid_i  (pe_valid),
    .pe_addr_i   (pe_addr),
    .head_addr_i (head_q),
    .mask_i      (mask_q),
    .collected_i (collected_q),
    .match_o     (match),
    .store_o     (store),
    .drop_o      (drop),
    .slot_oh_o   (slot_oh),
    .accepted_o  (accepted)
  );

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    mask_d      = mask_q;
    delim_d     = delim_q;
    collected_d = collected_q;
    results_d   = results_q;
    err_d       = err_q | (|drop);
    desc_ready  = 1'b0;
    pe_ready    = '0;
    load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        desc_ready = 1'b1;
        load       = desc_valid;
      end
      StCollect: begin
        pe_ready    = match;
        collected_d = collected_q | accepted;
        for (int i = 0; i < int'(NUM_HASH_PE); i++) begin
          for (int s = 0; s < int'(W); s++) begin
            if (store[i] && slot_oh[i*W + s]) begin
              results_d[s*RES_WIDTH +: RES_WIDTH] = pe_result[i*RES_WIDTH +: RES_WIDTH];
            end
          end
        end
        // An empty mask also satisfies this on the first collect cycle.
        if ((collected_q | accepted) == mask_q) state_d = StEmit;
      end
      StEmit: begin
        desc_ready = output_ready;
        if (output_ready) begin
          if (desc_valid) load = 1'b1;
          else            state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Fresh window: unfilled slots must read back as zero.
    if (load) begin
      head_d      = desc_head_addr;
      mask_d      = desc_mask;
      delim_d     = desc_delim;
      collected_d = '0;
      results_d   = '0;
      state_d     = StCollect;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      head_q      <= '0;
      mask_q      <= '0;
      delim_q     <= 1'b0;
      collected_q <= '0;
      results_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      mask_q      <= mask_d;
      delim_q     <= delim_d;
      collected_q <= collected_d;
      results_q   <= results_d;
      err_q       <= err_d;
    end
  end

  // Window fields are only driven while presented, so idle outputs read zero.
  always_comb begin
    output_valid      = (state_q == StEmit);
    output_head_addr  = output_valid ? head_q : '0;
    output_mask       = output_valid ? mask_q : '0;
    output_delim      = output_valid ? delim_q : 1'b0;
    output_result_vec = output_valid ? results_q : '0;
    err_unexpected    = err_q;
  end

endmodule

// File: tb/tb_post_hash_pe_gatherer.sv
module tb_post_hash_pe_gatherer;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_valid;
  logic          desc_ready;
  logic [31:0]   desc_head_addr;
  logic [7:0]    desc_mask;
  logic          desc_delim;
  logic [3:0]    pe_valid;
  logic [3:0]    pe_ready;
  logic [127:0]  pe_addr;
  logic [127:0]  pe_result;
  logic          output_valid;
  logic          output_ready;
  logic [31:0]   output_head_addr;
  logic [7:0]    output_mask;
  logic [255:0]  output_result_vec;
  logic          output_delim;
  logic          err_unexpected;

  post_hash_pe_gatherer dut (
    .clk               (clk),
    .rst               (rst),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_head_addr    (desc_head_addr),
    .desc_mask         (desc_mask),
    .desc_delim        (desc_delim),
    .pe_valid          (pe_valid),
    .pe_ready          (pe_ready),
    .pe_addr           (pe_addr),
    .pe_result         (pe_result),
    .output_valid      (output_valid),
    .output_ready      (output_ready),
    .output_head_addr  (output_head_addr),
    .output_mask       (output_mask),
    .output_result_vec (output_result_vec),
    .output_delim      (output_delim),
    .err_unexpected    (err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  head;
    logic [7:0]   mask;
    logic         delim;
    logic [255:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [7:0] m, input logic d,
                      input logic [255:0] r);
    exp_t e;
    e.head = h; e.mask = m; e.delim = d; e.res = r;
    exp_q.push_back(e);
  endtask

  function automatic logic [255:0] slot(input int s, input logic [31:0] v);
    logic [255:0] t;
    t = '0;
    t[s*32 +: 32] = v;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pe(input int i, input logic [31:0] a, input logic [31:0] r);
    pe_valid[i]         = 1'b1;
    pe_addr[i*32 +: 32] = a;
    pe_result[i*32 +: 32] = r;
  endtask

  task automatic send_desc(input logic [31:0] h, input logic [7:0] m, input logic d);
    desc_valid     = 1'b1;
    desc_head_addr = h;
    desc_mask      = m;
    desc_delim     = d;
  endtask

  // Scoreboard monitor: every accepted output window is matched to the oldest expected one.
  always @(negedge clk) begin
    if (!rst && output_valid && output_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_window: got head %0h, required no window", output_head_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("win_head",  output_head_addr,  e.head);
        chk("win_mask",  output_mask,       e.mask);
        chk("win_delim", output_delim,      e.delim);
        chk("win_res",   output_result_vec, e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    desc_valid = 0; desc_head_addr = 0; desc_mask = 0; desc_delim = 0;
    pe_valid = 0; pe_addr = 0; pe_result = 0;
    output_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_out_valid",  output_valid, 0);
    chk("rst_pe_ready",   pe_ready, 0);
    chk("rst_err",        err_unexpected, 0);

    // Four PEs fill slots 0-3 in one cycle
    tick(); send_desc(32'h100, 8'h0F, 0);
    push(32'h100, 8'h0F, 0, slot(0, 32'hA0) | slot(1, 32'hA1) | slot(2, 32'hA2) | slot(3, 32'hA3));
    tick(); desc_valid = 0;
    for (int i = 0; i < 4; i++) set_pe(i, 32'h100 + i, 32'hA0 + i);
    @(negedge clk);
    chk("full_pe_ready", pe_ready, 4'hF);
    chk("full_not_yet",  output_valid, 0);
    tick(); pe_valid = 0;
    @(negedge clk);
    chk("full_latency",  output_valid, 1);
    tick();

    // Empty mask window with delimiter
    send_desc(32'h200, 8'h00, 1);
    push(32'h200, 8'h00, 1, '0);
    @(negedge clk);
    chk("empty_desc_ready", desc_ready, 1);
    tick(); desc_valid = 0;
    @(negedge clk);
    chk("empty_lat1", output_valid, 0);
    tick();
    @(negedge clk);
    chk("empty_lat2", output_valid, 1);
    tick();

    // PE1 targets a later window and must stall until it opens
    send_desc(32'h100, 8'h01, 0);
    set_pe(1, 32'h108, 32'hB1);
    push(32'h100, 8'h01, 0, slot(0, 32'hB0));
    tick(); desc_valid = 0;
    @(negedge clk);
    chk("stall_pe1_a", pe_ready, 4'b0000);
    tick();
    @(negedge clk);
    chk("stall_pe1_b", pe_ready, 4'b0000);
    tick(); set_pe(0, 32'h100, 32'hB0);
    @(negedge clk);
    chk("stall_pe0_acc", pe_ready, 4'b0001);
    tick(); pe_valid[0] = 1'b0;
    send_desc(32'h108, 8'h01, 0);
    push(32'h108, 8'h01, 0, slot(0, 32'hB1));
    @(negedge clk);
    chk("b2b_emit",       output_valid, 1);
    chk("b2b_pe_ready",   pe_ready, 4'b0000);
    chk("b2b_desc_ready", desc_ready, 1);
    tick(); desc_valid = 0;
    @(negedge clk);
    chk("late_pe1_acc", pe_ready, 4'b0010);
    tick(); pe_valid = 0;
    @(negedge clk);
    chk("late_emit", output_valid, 1);
    tick();

    // Slot conflict: PE0 and PE2 both return slot 3
    send_desc(32'h300, 8'h08, 0);
    push(32'h300, 8'h08, 0, slot(3, 32'h11));
    tick(); desc_valid = 0;
    set_pe(0, 32'h303, 32'h11);
    set_pe(2, 32'h303, 32'h22);
    @(negedge clk);
    chk("conf_pe_ready", pe_ready, 4'b0101);
    chk("conf_err_pre",  err_unexpected, 0);
    tick(); pe_valid = 0;
    @(negedge clk);
    chk("conf_err",  err_unexpected, 1);
    chk("conf_emit", output_valid, 1);
    tick();

    // Output backpressure for 5 cycles, then back-to-back load on release
    output_ready = 1'b0;
    send_desc(32'h400, 8'h03, 0);
    push(32'h400, 8'h03, 0, slot(0, 32'h40) | slot(1, 32'h41));
    tick(); desc_valid = 0;
    set_pe(0, 32'h400, 32'h40);
    set_pe(1, 32'h401, 32'h41);
    tick(); pe_valid = 0;
    send_desc(32'h500, 8'h00, 0);
    push(32'h500, 8'h00, 0, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid",      output_valid, 1);
      chk("bp_desc_ready", desc_ready, 0);
      chk("bp_head",       output_head_addr, 32'h400);
      chk("bp_res",        output_result_vec, slot(0, 32'h40) | slot(1, 32'h41));
      tick();
    end
    output_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", desc_ready, 1);
    tick(); desc_valid = 0;
    @(negedge clk);
    chk("bp_next_collect", output_valid, 0);
    tick();
    @(negedge clk);
    chk("bp_next_emit", output_valid, 1);
    chk("err_sticky",   err_unexpected, 1);
    tick();

    // Reset with 3 of 4 slots collected discards the window
    send_desc(32'h600, 8'h0F, 0);
    tick(); desc_valid = 0;
    for (int i = 0; i < 3; i++) set_pe(i, 32'h600 + i, 32'h60 + i);
    tick(); pe_valid = 0;
    @(negedge clk);
    chk("part_no_out", output_valid, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", output_valid, 0);
    chk("mid_rst_mask",  output_mask, 0);
    chk("mid_rst_err",   err_unexpected, 0);
    chk("mid_rst_pe",    pe_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_desc_ready", desc_ready, 1);
    tick(); send_desc(32'h700, 8'h05, 0);
    push(32'h700, 8'h05, 0, slot(0, 32'h70) | slot(2, 32'h72));
    tick(); desc_valid = 0;
    set_pe(0, 32'h700, 32'h70);
    set_pe(3, 32'h702, 32'h72);
    @(negedge clk);
    chk("post_rst_pe_ready", pe_ready, 4'b1001);
    tick(); pe_valid = 0;
    @(negedge clk);
    chk("post_rst_emit", output_valid, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_err",     err_unexpected, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
